// File: rtl/rr_arb4_mux_if.sv
// Bundle of request, data and grant signals between the four requesters and rr_arb4_mux.
// Lock exists only when RR_ARB4_LOCK_EN is defined.

// Handshake: a requester raises Req[i] and keeps it high for as long as it wants the mux.
// Gnt[i] is the arbiter's acknowledgement. Mux_out is meaningful only in cycles where Out_valid is high.
// Dropping Req[i] releases the mux. There is no back-pressure on Mux_out.
interface rr_arb4_mux_if #(
   parameter int DATA_W = 8
);
   logic [3:0]        Req;
   logic [DATA_W-1:0] Data_a;
   logic [DATA_W-1:0] Data_b;
   logic [DATA_W-1:0] Data_c;
   logic [DATA_W-1:0] Data_d;
   logic [3:0]        Gnt;
   logic [1:0]        Sel;
   logic [DATA_W-1:0] Mux_out;
   logic              Out_valid;
   logic              State_dbg;
`ifdef RR_ARB4_LOCK_EN
   logic              Lock;

   modport master (
      output Req, Data_a, Data_b, Data_c, Data_d, Lock,
      input  Gnt, Sel, Mux_out, Out_valid, State_dbg
   );
   modport slave (
      input  Req, Data_a, Data_b, Data_c, Data_d, Lock,
      output Gnt, Sel, Mux_out, Out_valid, State_dbg
   );
`else
   modport master (
      output Req, Data_a, Data_b, Data_c, Data_d,
      input  Gnt, Sel, Mux_out, Out_valid, State_dbg
   );
   modport slave (
      input  Req, Data_a, Data_b, Data_c, Data_d,
      output Gnt, Sel, Mux_out, Out_valid, State_dbg
   );
`endif
endinterface

// File: rtl/rr_arb4_mux.sv
// Four-way round-robin arbiter that drives the select of a registered 4:1 data mux.
// Optional RR_ARB4_LOCK_EN adds a Lock input that suppresses the forced release.
module rr_arb4_mux #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 15
) (
   input  logic              Clk,
   input  logic              Rst_n,
   rr_arb4_mux_if.slave      bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_e            state_q, state_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [7:0]        hold_q, hold_d;
   logic [DATA_W-1:0] mux_out_q, mux_out_d;
   logic              out_valid_q, out_valid_d;

   logic [1:0]        win_idx;
   logic              win_found;
   logic [1:0]        cand;
   logic              others_pending;
   logic              lock_active;

`ifdef RR_ARB4_LOCK_EN
   assign lock_active = bus.Lock;
`else
   assign lock_active = 1'b0;
`endif

   // First requester at or after ptr, wrapping modulo 4.
   always_comb begin
      win_idx   = ptr_q;
      win_found = 1'b0;
      cand      = ptr_q;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!win_found && bus.Req[cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end

   assign others_pending = |(bus.Req & ~(4'b0001 << sel_q));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;

      case (state_q)
         IDLE: begin
            gnt_d = 4'b0000;
            if (win_found) begin
               gnt_d   = 4'b0001 << win_idx;
               sel_d   = win_idx;
               hold_d  = 8'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!bus.Req[sel_q] ||
                (others_pending && (hold_q == HOLD_LAST) && !lock_active)) begin
               gnt_d   = 4'b0000;
               ptr_d   = sel_q + 2'd1;
               state_d = IDLE;
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // Data path follows the registered select, so it lags the grant by one cycle.
   always_comb begin
      case (sel_q)
         2'd0:    mux_out_d = bus.Data_a;
         2'd1:    mux_out_d = bus.Data_b;
         2'd2:    mux_out_d = bus.Data_c;
         default: mux_out_d = bus.Data_d;
      endcase
      out_valid_d = (state_q == GRANT) && bus.Req[sel_q];
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 4'b0000;
         sel_q       <= 2'd0;
         ptr_q       <= 2'd0;
         hold_q      <= 8'd0;
         mux_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         mux_out_q   <= mux_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.Gnt       = gnt_q;
   assign bus.Sel       = sel_q;
   assign bus.Mux_out   = mux_out_q;
   assign bus.Out_valid = out_valid_q;
   assign bus.State_dbg = state_q;

endmodule

// File: tb/tb_rr_arb4_mux.sv
// Directed bench for rr_arb4_mux with MAX_HOLD=4; Lock steps run only when RR_ARB4_LOCK_EN is defined.
module tb_rr_arb4_mux;

   localparam int DATA_W = 8;

   logic Clk;
   logic Rst_n;
   int   n_checks;
   int   n_fail;

   rr_arb4_mux_if #(.DATA_W(DATA_W)) bus ();

   rr_arb4_mux #(.DATA_W(DATA_W), .MAX_HOLD(4)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [1:0]        exp_q[$];
   logic [3:0]        fr_gnt   [1:11];
   logic              fr_valid [1:11];
   logic [1:0]        h;

   function automatic logic [DATA_W-1:0] data_of(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h11;
         2'd1:    return 8'h22;
         2'd2:    return 8'h5A;
         default: return 8'h44;
      endcase
   endfunction

   // driver tasks
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      #2;
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      Rst_n       = 1'b0;
      bus.Req     = 4'b0000;
      bus.Data_a  = data_of(2'd0);
      bus.Data_b  = data_of(2'd1);
      bus.Data_c  = data_of(2'd2);
      bus.Data_d  = data_of(2'd3);
`ifdef RR_ARB4_LOCK_EN
      bus.Lock    = 1'b0;
`endif
      fr_gnt   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      fr_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // reset values
      #3;
      check("rst_gnt",   bus.Gnt,       4'b0000);
      check("rst_sel",   bus.Sel,       2'd0);
      check("rst_mux",   bus.Mux_out,   8'h00);
      check("rst_valid", bus.Out_valid, 1'b0);
      check("rst_state", bus.State_dbg, 1'b0);
      @(negedge Clk);
      Rst_n = 1'b1;
      step();
      check("idle_gnt", bus.Gnt, 4'b0000);

      // single requester C
      bus.Req = 4'b0100;
      step();
      check("single_gnt_e1",   bus.Gnt,       4'b0100);
      check("single_sel_e1",   bus.Sel,       2'd2);
      check("single_valid_e1", bus.Out_valid, 1'b0);
      step();
      check("single_valid_e2", bus.Out_valid, 1'b1);
      check("single_mux_e2",   bus.Mux_out,   8'h5A);
      for (int e = 3; e <= 10; e++) begin
         step();
         check("single_hold_gnt", bus.Gnt, 4'b0100);
      end
      bus.Req = 4'b0000;
      step();
      check("single_rel_gnt",   bus.Gnt,       4'b0000);
      check("single_rel_valid", bus.Out_valid, 1'b0);
      check("single_rel_sel",   bus.Sel,       2'd2);
      check("single_rel_mux",   bus.Mux_out,   8'h5A);

      // asynchronous reset in the middle of a grant
      bus.Req = 4'b0001;
      step();
      check("mid_gnt", bus.Gnt, 4'b0001);
      step();
      check("mid_valid", bus.Out_valid, 1'b1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("async_gnt",   bus.Gnt,       4'b0000);
      check("async_sel",   bus.Sel,       2'd0);
      check("async_mux",   bus.Mux_out,   8'h00);
      check("async_valid", bus.Out_valid, 1'b0);
      check("async_state", bus.State_dbg, 1'b0);
      bus.Req = 4'b1111;
      @(negedge Clk);
      Rst_n = 1'b1;

      // round-robin fairness with all four requesting
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd0);
      step();
      while (exp_q.size() > 0) begin
         h = exp_q.pop_front();
         check("rr_gnt", bus.Gnt, 4'b0001 << h);
         check("rr_sel", bus.Sel, h);
         bus.Req[h] = 1'b0;
         step();
         check("rr_bubble", bus.Gnt,     4'b0000);
         check("rr_mux",    bus.Mux_out, data_of(h));
         bus.Req[h] = 1'b1;
         step();
      end

      // forced release after four cycles
      bus.Req = 4'b0011;
      do_reset();
      for (int e = 1; e <= 11; e++) begin
         step();
         check("forced_gnt",   bus.Gnt,       fr_gnt[e]);
         check("forced_valid", bus.Out_valid, fr_valid[e]);
         if (e == 7) check("forced_mux_b", bus.Mux_out, 8'h22);
      end

      // lone holder keeps the mux, then yields once another request appears
      bus.Req = 4'b1000;
      do_reset();
      step();
      check("lone_first", bus.Gnt, 4'b1000);
      for (int e = 0; e < 20; e++) begin
         step();
         check("lone_hold", bus.Gnt, 4'b1000);
      end
      bus.Req = 4'b1001;
      step();
      check("lone_release", bus.Gnt, 4'b0000);
      step();
      check("lone_next_gnt", bus.Gnt, 4'b0001);
      check("lone_next_sel", bus.Sel, 2'd0);
      step();
      check("lone_next_valid", bus.Out_valid, 1'b1);
      check("lone_next_mux",   bus.Mux_out,   8'h11);

`ifdef RR_ARB4_LOCK_EN
      // Lock suppresses the forced release
      bus.Req  = 4'b0011;
      bus.Lock = 1'b1;
      do_reset();
      for (int e = 0; e < 12; e++) begin
         step();
         check("lock_hold", bus.Gnt, 4'b0001);
      end
      bus.Lock = 1'b0;
      step();
      check("lock_release", bus.Gnt, 4'b0000);
      step();
      check("lock_next", bus.Gnt, 4'b0010);
`endif

      // report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb4_mux.md
Name: rr_arb4_mux

Overview:
- Four-requester round-robin arbiter that owns the select of a 4:1 data mux and sequences access to it.
- The mux, the shared resource, sits inside the block.
- Each requester presents a data word. The granted requester's word is registered onto Mux_out with Out_valid.
- A hold counter bounds how long one requester keeps the mux while others are waiting.

Parameters:
- DATA_W, 8: width of each data input and of Mux_out.
- MAX_HOLD, 15: maximum consecutive GRANT cycles for one holder while any other request is pending; legal range 1..255.

Ports:
- Clk  input  1  rising-edge clock, single clock domain.
- Rst_n  input  1  asynchronous, active-low reset.
- Req  input  4  request vector; bit i = requester i (0=A, 1=B, 2=C, 3=D).
- Data_a  input  DATA_W  requester 0 data.
- Data_b  input  DATA_W  requester 1 data.
- Data_c  input  DATA_W  requester 2 data.
- Data_d  input  DATA_W  requester 3 data.
- Gnt  output  4  registered one-hot grant; all zero when no grant.
- Sel  output  2  registered mux select (index of current/last grantee).
- Mux_out  output  DATA_W  registered selected data.
- Out_valid  output  1  registered; Mux_out carries a granted requester's data this cycle.

Behaviour:
- Reset is asynchronous, active-low: Rst_n=0 forces all state immediately, regardless of Clk, including mid-grant.
  - state=IDLE, Gnt=0, Sel=0, Mux_out=0, Out_valid=0, ptr=0, hold_cnt=0.
- ptr (2 bits) is the highest-priority index for the next arbitration. Search order is ptr, ptr+1, ... modulo 4.
- Mux function: idx 0->Data_a, 1->Data_b, 2->Data_c, 3->Data_d.
- IDLE:
  - Req==0: stay; Gnt stays 0; Sel holds its last value.
  - Req!=0: winner w = first set bit in search order. Next edge: Gnt<=onehot(w), Sel<=w, hold_cnt<=0, state<=GRANT.
- GRANT (holder s=Sel):
  - Req[s]==0 (voluntary release): Gnt<=0, ptr<=s+1, state<=IDLE.
  - Req[s]==1 and (Req & ~onehot(s))!=0 and hold_cnt==MAX_HOLD-1 (forced release): Gnt<=0, ptr<=s+1, state<=IDLE.
  - Otherwise: stay in GRANT; hold_cnt<=hold_cnt+1, saturating at MAX_HOLD-1. It is not cleared while the holder stays alone.
- Every release costs exactly one IDLE bubble cycle (Gnt=0) before the next grant.
- Data path, every edge:
  - Mux_out <= mux(Sel).
  - Out_valid <= (state==GRANT) && Req[Sel].
- Latency:
  - Req rises at edge k (state IDLE) -> Gnt at k+1 -> first Out_valid=1 at k+2.
  - Mux_out at k+2 carries the data present in the cycle k+1..k+2.
- Out_valid falls one cycle after the holder drops Req.
- Mux_out holds its last mux(Sel) value while idle; consumers qualify it with Out_valid.
- Simultaneous events:
  - A requester asserting Req in the same cycle the holder releases is seen in the IDLE arbitration.
  - Req changes in GRANT never change Sel.
- hold_cnt width: 8 bits.

Optional Feature:
- Macro: RR_ARB4_LOCK_EN.
- Defined:
  - Adds input port Lock (1 bit).
  - When Lock=1 in GRANT, the forced-release condition is suppressed; hold_cnt still saturates.
  - Voluntary release is unaffected.
  - Lock is ignored in IDLE.
- Undefined:
  - No Lock port.
  - Forced release always applies per the rule above.

Test Plan:
- Reset: drive Rst_n=0 mid-GRANT between clock edges -> all outputs 0 immediately; first arbitration after release from reset starts at ptr=0.
- Single requester: Req=4'b0100 from edge 0, Data_c=8'h5A -> Gnt=4'b0100 and Sel=2 at edge 1; Out_valid=1 and Mux_out=8'h5A from edge 2; Req drops at edge 10 -> Gnt=0 at 11, Out_valid=0 at 11.
- Round-robin fairness: Req=4'b1111 held, each holder drops Req one cycle after its grant, then re-asserts -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Forced release: MAX_HOLD=4, Req=4'b0011 constant from reset -> requester 0 granted 4 cycles, Gnt=0 one cycle, requester 1 granted 4 cycles, back to 0.
- Lone holder: MAX_HOLD=4, only Req[3]=1 for 20 cycles -> Gnt=4'b1000 continuously, no release. Then Req[0] rises -> release on the next edge (hold_cnt saturated), Gnt=4'b0001 two cycles after Req[0] rose.
- RR_ARB4_LOCK_EN defined: MAX_HOLD=4, Req=4'b0011, Lock=1 -> requester 0 holds indefinitely. Lock=0 -> release on the next edge, requester 1 granted one cycle later.
